// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BHT of 2-bit saturating counters
// with a tagged BTB, trained by resolved outcomes from execute.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 32 - IDX_BITS - 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lk_valid,
    input  logic [31:0]      lk_pc,
    output logic             lk_hit,
    output logic             lk_taken,
    output logic [31:0]      lk_target,
    input  logic             up_valid,
    input  logic [31:0]      up_pc,
    input  logic [31:0]      up_target,
    input  logic             up_outcome,
    input  logic             up_pred,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic                valid_q  [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0] up_tag;
    logic                up_hit;
    logic                up_miss_pred;

    assign lk_idx = lk_pc[IDX_BITS+1:2];
    assign lk_tag = lk_pc[31:IDX_BITS+2];
    assign up_idx = up_pc[IDX_BITS+1:2];
    assign up_tag = up_pc[31:IDX_BITS+2];

    // Lookup reads the registered tables only, so a same-cycle update is not visible.
    assign lk_hit    = lk_valid & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit & ctr_q[lk_idx][1];
    assign lk_target = lk_taken ? target_q[lk_idx] : lk_pc + 32'd4;

    assign up_hit       = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
    assign up_miss_pred = up_outcome != up_pred;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            mispredict  <= 1'b0;
            redirect_pc <= 32'd0;
            br_count    <= '0;
            mp_count    <= '0;
        end else begin
            mispredict <= 1'b0;
            if (up_valid) begin
                mispredict  <= up_miss_pred;
                redirect_pc <= up_outcome ? up_target : up_pc + 32'd4;
                if (br_count != '1)
                    br_count <= br_count + CNT_W'(1);
                if (up_miss_pred && (mp_count != '1))
                    mp_count <= mp_count + CNT_W'(1);
                if (up_hit) begin
                    if (up_outcome)
                        ctr_q[up_idx] <= (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
                    else
                        ctr_q[up_idx] <= (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
                end else if (up_outcome) begin
                    valid_q[up_idx] <= 1'b1;
                    ctr_q[up_idx]   <= 2'b10;
                end
            end
        end
    end

    // Tag and target only matter once valid is set, so they need no reset.
    always_ff @(posedge clk) begin
        if (up_valid && up_outcome) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= up_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        lk_hit;
    logic        lk_taken;
    logic [31:0] lk_target;
    logic        up_valid;
    logic [31:0] up_pc;
    logic [31:0] up_target;
    logic        up_outcome;
    logic        up_pred;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mp_count;

    int vectors = 0;
    int miscompares = 0;

    branch_predictor dut (
        .clk(clk), .reset(reset),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
        .up_valid(up_valid), .up_pc(up_pc), .up_target(up_target), .up_outcome(up_outcome), .up_pred(up_pred),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && up_valid)
            assert (!$isunknown(up_outcome)) else $error("[TB] up_outcome unknown while up_valid=1");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one resolved branch for a single edge, leaving the registered result visible.
    task automatic applyStimulus(input logic [31:0] pc, input logic outcome,
                                 input logic [31:0] target, input logic pred);
        @(negedge clk);
        up_valid   = 1'b1;
        up_pc      = pc;
        up_outcome = outcome;
        up_target  = target;
        up_pred    = pred;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
    endtask

    task automatic lookupCheck(input string tag, input logic [31:0] pc, input logic exp_hit,
                               input logic exp_taken, input logic [31:0] exp_target);
        lk_valid = 1'b1;
        lk_pc    = pc;
        #1;
        checkOutput({tag, ".hit"}, {31'd0, lk_hit}, {31'd0, exp_hit});
        checkOutput({tag, ".taken"}, {31'd0, lk_taken}, {31'd0, exp_taken});
        checkOutput({tag, ".target"}, lk_target, exp_target);
    endtask

    task automatic mpCheck(input string tag, input logic exp_mp, input logic [31:0] exp_redirect);
        checkOutput({tag, ".mp"}, {31'd0, mispredict}, {31'd0, exp_mp});
        checkOutput({tag, ".redirect"}, redirect_pc, exp_redirect);
    endtask

    task automatic countCheck(input string tag, input logic [31:0] exp_br, input logic [31:0] exp_mp);
        checkOutput({tag, ".br_count"}, br_count, exp_br);
        checkOutput({tag, ".mp_count"}, mp_count, exp_mp);
    endtask

    initial begin
        reset      = 1'b0;
        lk_valid   = 1'b0;
        lk_pc      = 32'd0;
        up_valid   = 1'b0;
        up_pc      = 32'd0;
        up_target  = 32'd0;
        up_outcome = 1'b0;
        up_pred    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mpCheck("reset", 1'b0, 32'd0);
        countCheck("reset", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        lookupCheck("cold", 32'h100, 1'b0, 1'b0, 32'h104);
        lookupCheck("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        countCheck("cold", 32'd0, 32'd0);

        applyStimulus(32'h100, 1'b1, 32'h200, 1'b0);
        mpCheck("alloc", 1'b1, 32'h200);
        countCheck("alloc", 32'd1, 32'd1);
        lookupCheck("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        lookupCheck("lowbits", 32'h103, 1'b1, 1'b1, 32'h200);
        lk_valid = 1'b0;
        #1;
        checkOutput("nolookup.hit", {31'd0, lk_hit}, 32'd0);

        @(posedge clk);
        #1;
        mpCheck("idle", 1'b0, 32'h200);

        applyStimulus(32'h100, 1'b1, 32'h200, 1'b1);
        mpCheck("tk1", 1'b0, 32'h200);
        applyStimulus(32'h100, 1'b1, 32'h200, 1'b1);
        applyStimulus(32'h100, 1'b0, 32'h0, 1'b1);
        mpCheck("nt1", 1'b1, 32'h104);
        lookupCheck("ctr10", 32'h100, 1'b1, 1'b1, 32'h200);
        applyStimulus(32'h100, 1'b0, 32'h0, 1'b1);
        mpCheck("nt2", 1'b1, 32'h104);
        lookupCheck("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
        applyStimulus(32'h100, 1'b0, 32'h0, 1'b1);
        mpCheck("nt3", 1'b1, 32'h104);
        lookupCheck("ctr00", 32'h100, 1'b1, 1'b0, 32'h104);
        countCheck("train", 32'd6, 32'd4);

        applyStimulus(32'h100, 1'b0, 32'h0, 1'b0);
        applyStimulus(32'h180, 1'b0, 32'h0, 1'b0);
        lookupCheck("nomiss_alloc", 32'h180, 1'b0, 1'b0, 32'h184);
        applyStimulus(32'h100, 1'b1, 32'h200, 1'b0);
        lookupCheck("sat0", 32'h100, 1'b1, 1'b0, 32'h104);
        countCheck("sat0", 32'd9, 32'd5);

        // Same-cycle lookup and update: the 01->10 transition is not bypassed.
        @(negedge clk);
        lk_valid   = 1'b1;
        lk_pc      = 32'h100;
        up_valid   = 1'b1;
        up_pc      = 32'h100;
        up_outcome = 1'b1;
        up_target  = 32'h200;
        up_pred    = 1'b0;
        #1;
        checkOutput("samecyc.pre", {31'd0, lk_taken}, 32'd0);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        checkOutput("samecyc.post", {31'd0, lk_taken}, 32'd1);

        applyStimulus(32'h200, 1'b1, 32'h300, 1'b0);
        mpCheck("alias", 1'b1, 32'h300);
        lookupCheck("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        lookupCheck("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
        countCheck("alias", 32'd11, 32'd7);

        applyStimulus(32'h200, 1'b0, 32'h0, 1'b1);
        mpCheck("pre_rst", 1'b1, 32'h204);
        reset = 1'b0;
        #1;
        mpCheck("in_rst", 1'b0, 32'h0);
        countCheck("in_rst", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        lookupCheck("post_rst", 32'h200, 1'b0, 1'b0, 32'h204);
        countCheck("post_rst", 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
